// File: rtl/mips32_mem_arbiter_if.sv
// Pipeline-to-memory bus bundle for the unified memory arbiter.
// Carries the instruction-fetch port, the data port, the halt qualifier and
// the single-port memory array connection.
//   slave  : arbiter view (takes requests and read data, drives grants and memory)
//   master : pipeline/memory view (drives requests and read data, takes grants)
interface mips32_mem_arbiter_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
);
    // pipeline control
    logic          halt;

    // instruction fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    // data port
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;

    // memory array side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  halt,
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output halt,
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Single-port unified memory arbiter between instruction fetch and data access.
// Data access wins by default; a starvation counter forces an IF grant after
// STARVE_MAX consecutive denied IF cycles. Halt removes IF eligibility.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus          fetch/data/memory bundle (slave modport)
//   conflict_cnt saturating count of cycles where both requesters were eligible
module mips32_mem_arbiter #(
    parameter int unsigned AW         = 10,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    mips32_mem_arbiter_if.slave bus,
    output logic [15:0]         conflict_cnt
);
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 16;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    logic          if_elig_c;
    logic          dm_elig_c;
    logic          if_gnt_c;
    logic          dm_gnt_c;
    logic          mem_en_c;
    logic          mem_we_c;
    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_wdata_c;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt_c;
    logic [CW-1:0] conflict_q;
    logic          rd_if;
    logic          rd_dm;

    // Eligibility and priority decision; grants are suppressed while in reset.
    always_comb begin
        if_elig_c = bus.if_req & ~bus.halt;
        dm_elig_c = bus.dm_req;
        if_gnt_c  = 1'b0;
        dm_gnt_c  = 1'b0;
        if (!rst) begin
            if (if_elig_c && (starve_cnt == STARVE_LIM)) begin
                if_gnt_c = 1'b1;
            end else if (dm_elig_c) begin
                dm_gnt_c = 1'b1;
            end else if (if_elig_c) begin
                if_gnt_c = 1'b1;
            end
        end
    end

    // Memory port mux; unused fields are driven 0 when idle.
    always_comb begin
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (if_gnt_c) begin
            mem_en_c   = 1'b1;
            mem_addr_c = bus.if_addr;
        end else if (dm_gnt_c) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.dm_we;
            mem_addr_c  = bus.dm_addr;
            mem_wdata_c = bus.dm_wdata;
        end
    end

    // Starvation counter: counts denied eligible IF cycles, saturates at the limit.
    always_comb begin
        starve_nxt_c = starve_cnt;
        if (!if_elig_c || if_gnt_c) begin
            starve_nxt_c = '0;
        end else if (starve_cnt < STARVE_LIM) begin
            starve_nxt_c = starve_cnt + SW'(1);
        end
    end

    // State: starvation count, read owner flags, conflict counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            rd_if      <= 1'b0;
            rd_dm      <= 1'b0;
            conflict_q <= '0;
        end else begin
            starve_cnt <= starve_nxt_c;
            rd_if      <= if_gnt_c;
            // stores are acknowledged by the grant alone, no read return
            rd_dm      <= dm_gnt_c & ~bus.dm_we;
            if (if_elig_c && dm_elig_c && (conflict_q != CNT_MAX)) begin
                conflict_q <= conflict_q + CW'(1);
            end
        end
    end

    assign bus.if_gnt    = if_gnt_c;
    assign bus.dm_gnt    = dm_gnt_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;

    // Read data is only exposed to the owner of the returning access.
    assign bus.if_rvalid = rd_if;
    assign bus.dm_rvalid = rd_dm;
    assign bus.if_rdata  = rd_if ? bus.mem_rdata : '0;
    assign bus.dm_rdata  = rd_dm ? bus.mem_rdata : '0;

    assign conflict_cnt  = conflict_q;
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Scoreboard bench for mips32_mem_arbiter: stimulus pushes expected grants and
// read data into queues; a negedge monitor pops and compares on DUT events.
module tb_mips32_mem_arbiter;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic          is_dm;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gnt_t;

    logic        clk;
    logic        rst;
    logic [15:0] conflict_cnt;

    mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    int checks   = 0;
    int failures = 0;

    gnt_t          gnt_q[$];
    logic [DW-1:0] if_q[$];
    logic [DW-1:0] dm_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory array model: 1-cycle read latency, write at the grant edge.
    logic [DW-1:0] tb_mem [0:1023];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= tb_mem[bus.mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic report_unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor: protocol checks every cycle, scoreboard pops on grants/rvalids.
    logic prev_if_gnt = 1'b0;
    logic prev_dm_ld  = 1'b0;
    always @(negedge clk) begin
        gnt_t act;
        check("gnt_exclusive", 64'(bus.if_gnt & bus.dm_gnt), 64'(0));
        check("mem_en_vs_gnt", 64'(bus.mem_en), 64'(bus.if_gnt | bus.dm_gnt));
        if (bus.if_rvalid) check("if_rvalid_cause", 64'(prev_if_gnt), 64'(1));
        if (bus.dm_rvalid) check("dm_rvalid_cause", 64'(prev_dm_ld), 64'(1));
        if (!bus.if_rvalid) check("if_rdata_idle", 64'(bus.if_rdata), 64'(0));
        if (!bus.dm_rvalid) check("dm_rdata_idle", 64'(bus.dm_rdata), 64'(0));
        if (bus.if_gnt || bus.dm_gnt) begin
            act.is_dm = bus.dm_gnt;
            act.we    = bus.mem_we;
            act.addr  = bus.mem_addr;
            act.wdata = (bus.dm_gnt && bus.mem_we) ? bus.mem_wdata : '0;
            if (gnt_q.size() == 0) report_unexpected("grant");
            else check("grant", 64'(act), 64'(gnt_q.pop_front()));
        end
        if (bus.if_rvalid) begin
            if (if_q.size() == 0) report_unexpected("if_rvalid");
            else check("if_rdata", 64'(bus.if_rdata), 64'(if_q.pop_front()));
        end
        if (bus.dm_rvalid) begin
            if (dm_q.size() == 0) report_unexpected("dm_rvalid");
            else check("dm_rdata", 64'(bus.dm_rdata), 64'(dm_q.pop_front()));
        end
        prev_if_gnt = bus.if_gnt;
        prev_dm_ld  = bus.dm_gnt & ~bus.mem_we;
    end

    task automatic exp_if(input logic [AW-1:0] a, input logic [DW-1:0] d);
        gnt_q.push_back('{is_dm: 1'b0, we: 1'b0, addr: a, wdata: '0});
        if_q.push_back(d);
    endtask

    task automatic exp_ld(input logic [AW-1:0] a, input logic [DW-1:0] d);
        gnt_q.push_back('{is_dm: 1'b1, we: 1'b0, addr: a, wdata: '0});
        dm_q.push_back(d);
    endtask

    task automatic exp_st(input logic [AW-1:0] a, input logic [DW-1:0] d);
        gnt_q.push_back('{is_dm: 1'b1, we: 1'b1, addr: a, wdata: d});
    endtask

    task automatic set_in(input logic ir, input logic [AW-1:0] ia, input logic dr,
                          input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                          input logic h);
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.dm_req   = dr;
        bus.dm_we    = dw;
        bus.dm_addr  = da;
        bus.dm_wdata = dd;
        bus.halt     = h;
    endtask

    // One clock cycle with the given inputs, ending 1 time unit after the edge.
    task automatic cyc(input logic ir, input logic [AW-1:0] ia, input logic dr,
                       input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                       input logic h);
        set_in(ir, ia, dr, dw, da, dd, h);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic check_drained(input string name);
        check(name, 64'(gnt_q.size() + if_q.size() + dm_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both requests asserted: nothing may be granted.
        rst = 1'b1;
        set_in(1'b1, 10'd5, 1'b1, 1'b0, 10'd20, '0, 1'b0);
        bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_if_gnt",    64'(bus.if_gnt),    64'(0));
        check("rst_dm_gnt",    64'(bus.dm_gnt),    64'(0));
        check("rst_mem_en",    64'(bus.mem_en),    64'(0));
        check("rst_if_rvalid", 64'(bus.if_rvalid), 64'(0));
        check("rst_dm_rvalid", 64'(bus.dm_rvalid), 64'(0));
        check("rst_conflict",  64'(conflict_cnt),  64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check("idle_mem_en",   64'(bus.mem_en),   64'(0));
        check("idle_conflict", 64'(conflict_cnt), 64'(0));
        @(posedge clk);
        #1;

        // Preload program/data words through the data port.
        exp_st(10'd5, 32'h0022_2000);
        cyc(1'b0, '0, 1'b1, 1'b1, 10'd5, 32'h0022_2000, 1'b0);
        exp_st(10'd20, 32'hA5A5_0014);
        cyc(1'b0, '0, 1'b1, 1'b1, 10'd20, 32'hA5A5_0014, 1'b0);
        idle(1);

        // Solo fetch, 4 back-to-back grants.
        for (int i = 0; i < 4; i++) begin
            exp_if(10'd5, 32'h0022_2000);
            cyc(1'b1, 10'd5, 1'b0, 1'b0, '0, '0, 1'b0);
        end
        idle(2);
        check("solo_conflict", 64'(conflict_cnt), 64'(0));
        check_drained("solo_drained");

        // Contention: DM wins until IF has been denied 3 times.
        for (int i = 0; i < 8; i++) begin
            if ((i % 4) == 3) exp_if(10'd5, 32'h0022_2000);
            else              exp_ld(10'd20, 32'hA5A5_0014);
            cyc(1'b1, 10'd5, 1'b1, 1'b0, 10'd20, '0, 1'b0);
        end
        idle(2);
        check("prio_conflict", 64'(conflict_cnt), 64'(8));
        check_drained("prio_drained");

        // Store then load of the same word.
        exp_st(10'd7, 32'h0000_001E);
        cyc(1'b0, '0, 1'b1, 1'b1, 10'd7, 32'h0000_001E, 1'b0);
        exp_ld(10'd7, 32'h0000_001E);
        cyc(1'b0, '0, 1'b1, 1'b0, 10'd7, '0, 1'b0);
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check("sl_dm_rvalid", 64'(bus.dm_rvalid), 64'(1));
        check("sl_dm_rdata",  64'(bus.dm_rdata),  64'(32'h0000_001E));
        @(posedge clk);
        #1;
        idle(1);
        check_drained("sl_drained");

        // Halt: fetches stop from cycle 4, data port keeps working.
        for (int i = 0; i < 3; i++) begin
            exp_if(10'd5, 32'h0022_2000);
            cyc(1'b1, 10'd5, 1'b0, 1'b0, '0, '0, 1'b0);
        end
        cyc(1'b1, 10'd5, 1'b0, 1'b0, '0, '0, 1'b1);
        exp_st(10'd9, 32'h0000_0005);
        cyc(1'b1, 10'd5, 1'b1, 1'b1, 10'd9, 32'h0000_0005, 1'b1);
        set_in(1'b1, 10'd5, 1'b0, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        check("halt_starve", 64'(dut.starve_cnt), 64'(0));
        check("halt_if_gnt", 64'(bus.if_gnt),     64'(0));
        @(posedge clk);
        #1;
        exp_ld(10'd9, 32'h0000_0005);
        cyc(1'b1, 10'd5, 1'b1, 1'b0, 10'd9, '0, 1'b1);
        idle(2);
        check("halt_conflict", 64'(conflict_cnt), 64'(8));
        check_drained("halt_drained");

        // Reset mid-operation: granted fetch must not return.
        exp_if(10'd5, 32'h0022_2000);
        if_q.pop_back();
        set_in(1'b1, 10'd5, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_if_gnt", 64'(bus.if_gnt), 64'(0));
        check("rstmid_mem_en", 64'(bus.mem_en), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstmid_if_rvalid", 64'(bus.if_rvalid), 64'(0));
        end
        check("rstmid_conflict", 64'(conflict_cnt), 64'(0));
        @(posedge clk);
        #1;
        check_drained("final_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
